// File: rtl/serial_tx_fifo.sv
// Byte FIFO between the system bus and the slow-clock UART transmitter.
// Bytes are offered one at a time through the data_avail / send_strobe handshake.
module serial_tx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [7:0]            send_data,
    output logic                  data_avail,
    input  logic                  send_strobe
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        SENDING
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0]  rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2:0]    level_q, level_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             sendData_q, sendData_d;
    logic                   dataAvail_q, dataAvail_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   strobeS;
    logic                   wrAccept;
    logic                   wrDrop;
    logic                   pop;
    logic                   load;

    // Preset to 1 so the transmitter's reset-idle level is seen without a false busy period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], send_strobe};
        end
    end

    assign strobeS = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            sendData_q  <= 8'h00;
            dataAvail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            sendData_q  <= sendData_d;
            dataAvail_q <= dataAvail_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wrAccept) begin
            mem_q[wrPtr_q] <= wr_data;
        end
    end

    // SENDING waits for the transmitter to go idle again so a byte is never offered twice.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q && strobeS) begin
                    load    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (!strobeS) begin
                    pop     = 1'b1;
                    state_d = SENDING;
                end
            end
            SENDING: begin
                if (strobeS) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        dataAvail_d = (state_d == OFFER);
    end

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    always_comb begin
        wrAccept = wr_en && !full_q;
        wrDrop   = wr_en && full_q;
        wrPtr_d  = wrAccept ? wrPtr_q + PTR_ONE : wrPtr_q;
        rdPtr_d  = pop ? rdPtr_q + PTR_ONE : rdPtr_q;
        case ({wrAccept, pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == FULL_LEVEL);
        empty_d = (level_d == '0);
        if (wrDrop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        sendData_d = load ? mem_q[rdPtr_q] : sendData_q;
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign send_data  = sendData_q;
    assign data_avail = dataAvail_q;

endmodule
